stump_control: RTL and testbench

STUMP_CONTROL -- requirements
Module: Stump_control

---
 rtl/stump_control.sv | 150 +++++++++++++++
 tb/tb_stump_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stump_control.sv
// Control unit for the STUMP processor: a FETCH/EXECUTE/MEMORY sequencer that decodes
// the instruction register into datapath selects and strobes, and holds the condition codes.
module stump_control #(
    parameter logic [2:0] PC_INDEX = 3'd7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir,
    input  logic [3:0]  flags_in,
    output logic        fetch,
    output logic [2:0]  alu_func,
    output logic        c_in,
    output logic [1:0]  opB_sel,
    output logic [1:0]  shift_op,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic [2:0]  dest,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [3:0]  cc_out,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10,
        UNUSED  = 2'b11
    } state_t;

    state_t cur_state, next_state;

    logic [2:0] opcode;
    logic       is_alu, is_ldst;
    logic       cond_true;
    logic       flag_n, flag_z, flag_v, flag_c;

    assign opcode  = ir[15:13];
    assign is_alu  = (opcode < 3'b110);
    assign is_ldst = (opcode == 3'b110);
    assign state   = cur_state;
    assign c_in    = cc_out[0];

    assign {flag_n, flag_z, flag_v, flag_c} = cc_out;

    always_comb begin
        case (ir[11:8])
            4'h0:    cond_true = 1'b1;
            4'h1:    cond_true = 1'b0;
            4'h2:    cond_true = ~flag_c & ~flag_z;
            4'h3:    cond_true = flag_c | flag_z;
            4'h4:    cond_true = ~flag_c;
            4'h5:    cond_true = flag_c;
            4'h6:    cond_true = ~flag_z;
            4'h7:    cond_true = flag_z;
            4'h8:    cond_true = ~flag_v;
            4'h9:    cond_true = flag_v;
            4'hA:    cond_true = ~flag_n;
            4'hB:    cond_true = flag_n;
            4'hC:    cond_true = (flag_n == flag_v);
            4'hD:    cond_true = (flag_n != flag_v);
            4'hE:    cond_true = ~flag_z & (flag_n == flag_v);
            default: cond_true = flag_z | (flag_n != flag_v);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Only ALU instructions with the S bit (ir[11]) update the condition codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_out <= 4'b0000;
        end else if (cur_state == EXECUTE && is_alu && ir[11]) begin
            cc_out <= flags_in;
        end
    end

    always_comb begin
        next_state = FETCH;
        fetch      = 1'b0;
        alu_func   = 3'b000;
        opB_sel    = 2'b00;
        shift_op   = 2'b00;
        srcA       = 3'b000;
        srcB       = 3'b000;
        dest       = 3'b000;
        reg_write  = 1'b0;
        wb_sel     = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;

        case (cur_state)
            EXECUTE: begin
                next_state = is_ldst ? MEMORY : FETCH;
                if (is_alu || is_ldst) begin
                    alu_func = opcode;
                    srcA     = ir[7:5];
                    if (ir[12]) begin
                        opB_sel = 2'b01;
                    end else begin
                        opB_sel  = 2'b00;
                        srcB     = ir[4:2];
                        shift_op = ir[1:0];
                    end
                    if (is_alu) begin
                        dest      = ir[10:8];
                        reg_write = 1'b1;
                    end
                end else begin
                    alu_func  = 3'b111;
                    srcA      = PC_INDEX;
                    opB_sel   = 2'b11;
                    dest      = PC_INDEX;
                    reg_write = cond_true;
                end
            end
            MEMORY: begin
                next_state = FETCH;
                if (ir[11]) begin
                    mem_wen = 1'b1;
                    srcA    = ir[10:8];
                end else begin
                    mem_ren   = 1'b1;
                    reg_write = 1'b1;
                    wb_sel    = 1'b1;
                    dest      = ir[10:8];
                end
            end
            // The unreachable encoding behaves exactly like FETCH.
            default: begin
                next_state = EXECUTE;
                fetch      = 1'b1;
                mem_ren    = 1'b1;
                srcA       = PC_INDEX;
                opB_sel    = 2'b10;
                dest       = PC_INDEX;
                reg_write  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_stump_control.sv
// Self-checking bench for stump_control: an instruction-level model predicts every output
// each cycle, alongside hand-computed checks of the worked examples and reset behaviour.
module tb_stump_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ir;
    logic [3:0]  flags_in;
    logic        fetch;
    logic [2:0]  alu_func;
    logic        c_in;
    logic [1:0]  opB_sel;
    logic [1:0]  shift_op;
    logic [2:0]  srcA, srcB, dest;
    logic        reg_write, wb_sel, mem_ren, mem_wen;
    logic [3:0]  cc_out;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Model: which cycle of the current instruction we are in, plus the condition codes.
    int       m_step;
    logic [3:0] m_cc;

    stump_control #(.PC_INDEX(3'd7)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .flags_in(flags_in),
        .fetch(fetch), .alu_func(alu_func), .c_in(c_in), .opB_sel(opB_sel),
        .shift_op(shift_op), .srcA(srcA), .srcB(srcB), .dest(dest),
        .reg_write(reg_write), .wb_sel(wb_sel), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .cc_out(cc_out), .state(state)
    );

    always #5 clk = ~clk;

    function automatic int instr_len(input logic [15:0] i);
        return (i[15:13] == 3'b110) ? 3 : 2;
    endfunction

    // Even conditions are the base test; each odd condition is its partner's negation.
    function automatic logic branch_taken(input logic [3:0] c, input logic [3:0] cc);
        logic n, z, v, cy, base;
        {n, z, v, cy} = cc;
        case (c[3:1])
            3'd0:    base = 1'b1;
            3'd1:    base = ~cy & ~z;
            3'd2:    base = ~cy;
            3'd3:    base = ~z;
            3'd4:    base = ~v;
            3'd5:    base = ~n;
            3'd6:    base = (n == v);
            default: base = ~z & (n == v);
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [27:0] expected_outputs(input int step, input logic [15:0] i,
                                                     input logic [3:0] cc);
        logic       f, rw, wb, mr, mw;
        logic [2:0] af, sa, sb, d;
        logic [1:0] ob, sh;
        {f, rw, wb, mr, mw} = '0;
        {af, sa, sb, d} = '0;
        {ob, sh} = '0;
        if (step == 0) begin
            f = 1'b1; mr = 1'b1; sa = 3'd7; ob = 2'b10; d = 3'd7; rw = 1'b1;
        end else if (step == 1) begin
            af = i[15:13];
            if (i[15:13] == 3'b111) begin
                sa = 3'd7; ob = 2'b11; d = 3'd7; rw = branch_taken(i[11:8], cc);
            end else begin
                sa = i[7:5];
                if (i[12]) ob = 2'b01;
                else begin
                    sb = i[4:2]; sh = i[1:0];
                end
                if (i[15:13] != 3'b110) begin
                    d = i[10:8]; rw = 1'b1;
                end
            end
        end else begin
            if (i[11]) begin
                mw = 1'b1; sa = i[10:8];
            end else begin
                mr = 1'b1; rw = 1'b1; wb = 1'b1; d = i[10:8];
            end
        end
        return {f, af, cc[0], ob, sh, sa, sb, d, rw, wb, mr, mw, cc, 2'(step)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step <= 0;
            m_cc   <= 4'b0000;
        end else begin
            if (m_step == 1 && ir[15:13] < 3'b110 && ir[11]) m_cc <= flags_in;
            m_step <= (m_step + 1 >= instr_len(ir)) ? 0 : m_step + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cycle_outputs",
                {4'b0, fetch, alu_func, c_in, opB_sel, shift_op, srcA, srcB, dest,
                 reg_write, wb_sel, mem_ren, mem_wen, cc_out, state},
                {4'b0, expected_outputs(m_step, ir, m_cc)});
        end
    end

    task automatic alignFetch();
        int n = 0;
        while (m_step != 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (m_step != 0) checkOutput("align_timeout", 32'(m_step), 32'd0);
    endtask

    // Loads an instruction during FETCH and returns at the negedge inside its EXECUTE cycle.
    task automatic applyStimulus(input logic [15:0] ir_v, input logic [3:0] flags_v);
        alignFetch();
        #1;
        ir       = ir_v;
        flags_in = flags_v;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        ir       = 16'h0000;
        flags_in = 4'b0000;
        #3;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_cc", 32'(cc_out), 32'd0);
        checkOutput("reset_fetch", 32'(fetch), 32'd1);
        #9 rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'h0A2C, 4'b0101);
        checkOutput("adds_alu_func", 32'(alu_func), 32'd0);
        checkOutput("adds_dest", 32'(dest), 32'd2);
        checkOutput("adds_srcA", 32'(srcA), 32'd1);
        checkOutput("adds_srcB", 32'(srcB), 32'd3);
        checkOutput("adds_opB_sel", 32'(opB_sel), 32'd0);
        checkOutput("adds_reg_write", 32'(reg_write), 32'd1);
        @(negedge clk);
        checkOutput("adds_cc", 32'(cc_out), 32'h5);
        checkOutput("adds_state_after", 32'(state), 32'd0);

        applyStimulus(16'h022C, 4'b1111);
        @(negedge clk);
        checkOutput("add_nos_cc_hold", 32'(cc_out), 32'h5);

        applyStimulus(16'hD385, 4'b1111);
        checkOutput("ld_exec_opB_sel", 32'(opB_sel), 32'd1);
        checkOutput("ld_exec_reg_write", 32'(reg_write), 32'd0);
        @(negedge clk);
        checkOutput("ld_mem_state", 32'(state), 32'd2);
        checkOutput("ld_mem_ctrl", 32'({mem_ren, reg_write, wb_sel, dest}), 32'h3B);
        @(negedge clk);
        checkOutput("ld_back_to_fetch", 32'(state), 32'd0);

        applyStimulus(16'h0A2C, 4'b0100);
        applyStimulus(16'hF7FE, 4'b1011);
        checkOutput("beq_taken_rw", 32'(reg_write), 32'd1);
        checkOutput("beq_taken_dest", 32'(dest), 32'd7);
        checkOutput("beq_taken_opB", 32'(opB_sel), 32'd3);
        @(negedge clk);
        checkOutput("beq_cc_hold", 32'(cc_out), 32'h4);
        applyStimulus(16'h0A2C, 4'b0000);
        applyStimulus(16'hF7FE, 4'b1111);
        checkOutput("beq_nottaken_rw", 32'(reg_write), 32'd0);
        @(negedge clk);
        checkOutput("beq_nottaken_cc", 32'(cc_out), 32'h0);

        applyStimulus(16'h0A2C, 4'b1010);
        applyStimulus(16'hD985, 4'b0000);
        @(negedge clk);
        #1 checkOutput("st_mem_wen", 32'(mem_wen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_state", 32'(state), 32'd0);
        checkOutput("abort_cc", 32'(cc_out), 32'd0);
        checkOutput("abort_mem_wen", 32'(mem_wen), 32'd0);
        checkOutput("abort_fetch_ren", 32'({fetch, mem_ren}), 32'd3);
        ir = 16'h0000;
        #4 rst_n = 1'b1;
        @(negedge clk);

        for (int cc = 0; cc < 16; cc++) begin
            applyStimulus(16'h0800, 4'(cc));
            for (int c = 0; c < 16; c++) begin
                logic [3:0] cv;
                cv = 4'(c);
                applyStimulus({4'b1110, cv, 8'hF0}, 4'hF);
                checkOutput("branch_cond", 32'(reg_write), 32'(branch_taken(cv, 4'(cc))));
            end
        end
        alignFetch();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
